// File: rtl/regfile_pkg.sv
// Shared defaults for the parametrised integer register file
// and its pending-register scoreboard.
package regfile_pkg;
    localparam int WIDTH_DEF    = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NREAD_DEF    = 2;
    localparam bit ZERO_REG_DEF = 1'b1;
endpackage

// File: rtl/pending_scoreboard.sv
// Per-register pending bits with reserve/clear/flush priority,
// an incrementally maintained pending count and a sticky wb_err flag.
module pending_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic [ADDR_W:0]          busy_count,
    output logic                     wb_err
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rsv_ok, wb_zero, same, inc, dec;

    always_comb begin
        rsv_ok  = rsv_en & ~(ZERO_REG & (rsv_addr == '0));
        wb_zero = ZERO_REG & (wb_addr == '0);
        same    = rsv_en & (rsv_addr == wb_addr);
        pend_d  = pend_q;
        if (flush) pend_d = '0;
        if (wb_en) pend_d[wb_addr] = 1'b0;
        // a reserve overrides any clear landing on the same register
        if (rsv_ok) pend_d[rsv_addr] = 1'b1;
        inc = rsv_ok & ~pend_q[rsv_addr];
        dec = wb_en & pend_q[wb_addr] & ~(rsv_ok & (rsv_addr == wb_addr));
        if (flush)
            cnt_d = {{ADDR_W{1'b0}}, rsv_ok};
        else
            cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        err_d = err_q | (wb_en & ~pend_q[wb_addr] & ~wb_zero & ~same);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign pending    = pend_q;
    assign busy_count = cnt_q;
    assign wb_err     = err_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with ALU and load-return write ports, bypassed
// operand reads, a raw debug read and a pending scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [WIDTH-1:0]        dbg_data,
    input  logic                    wa_en,
    input  logic [ADDR_W-1:0]       wa_addr,
    input  logic [WIDTH-1:0]        wa_data,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic                    flush,
    output logic [ADDR_W:0]         busy_count,
    output logic                    wb_err
);
    localparam int NREGS = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending;
    logic             wa_ok, wb_ok;

    pending_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .flush      (flush),
        .pending    (pending),
        .busy_count (busy_count),
        .wb_err     (wb_err)
    );

    always_comb begin
        wa_ok  = wa_en & ~(ZERO_REG & (wa_addr == '0));
        wb_ok  = wb_en & ~(ZERO_REG & (wb_addr == '0));
        regs_d = regs_q;
        if (wb_ok) regs_d[wb_addr] = wb_data;
        // port A is applied last so it wins an address collision
        if (wa_ok) regs_d[wa_addr] = wa_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        always_comb begin
            d = regs_q[a];
            if (ZERO_REG && a == '0)
                d = '0;
            else if (wa_en && wa_addr == a)
                d = wa_data;
            else if (wb_en && wb_addr == a)
                d = wb_data;
        end
        assign rd_data[k*WIDTH +: WIDTH] = d;
        assign rd_busy[k] = pending[a] & ~(wb_en & (wb_addr == a)) & ~flush;
    end

    assign dbg_data = regs_q[dbg_addr];
endmodule
